// File: rtl/gate_tt_checker.sv
// Truth-table sweeper: drives every N_IN-bit vector, waits SETTLE cycles, samples and compares to EXP_TT.
// Optional GATE_TT_STOP_ON_FAIL_EN: the first mismatch ends the sweep immediately.
module gate_tt_checker #(
   parameter int                      N_IN   = 2,
   parameter int                      SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]    EXP_TT = 4'b1110
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [N_IN-1:0]       stim,
   input  logic                  dut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_IN:0]         fail_cnt,
   output logic [N_IN-1:0]       first_fail,
   output logic [(1<<N_IN)-1:0]  obs_tt
);

   localparam int NV = 1 << N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] STIM_ONE = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [N_IN:0]   FCNT_ONE = {{N_IN{1'b0}}, 1'b1};
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   stim_q, stim_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_IN:0]     fail_cnt_q, fail_cnt_d;
   logic [N_IN-1:0]   first_fail_q, first_fail_d;
   logic [NV-1:0]     obs_tt_q, obs_tt_d;
   logic              pass_q, pass_d;
   logic              mismatch;
   logic              finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         stim_q       <= '0;
         cnt_q        <= '0;
         fail_cnt_q   <= '0;
         first_fail_q <= '0;
         obs_tt_q     <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         stim_q       <= stim_d;
         cnt_q        <= cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         first_fail_q <= first_fail_d;
         obs_tt_q     <= obs_tt_d;
         pass_q       <= pass_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      stim_d       = stim_q;
      cnt_d        = cnt_q;
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;
      obs_tt_d     = obs_tt_q;
      pass_d       = pass_q;
      // Case-inequality so an X/Z gate output is reported as a failure.
      mismatch     = (dut_out !== EXP_TT[stim_q]);
      finish       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_WAIT;
               stim_d       = '0;
               cnt_d        = '0;
               fail_cnt_d   = '0;
               first_fail_d = '0;
               obs_tt_d     = '0;
               pass_d       = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_SAMPLE: begin
            obs_tt_d[stim_q] = dut_out;
            if (mismatch) begin
               fail_cnt_d = fail_cnt_q + FCNT_ONE;
               if (fail_cnt_q == '0) begin
                  first_fail_d = stim_q;
               end
            end
`ifdef GATE_TT_STOP_ON_FAIL_EN
            finish = mismatch || (stim_q == LAST_IDX);
`else
            finish = (stim_q == LAST_IDX);
`endif
            if (finish) begin
               state_d = S_DONE;
               pass_d  = (fail_cnt_d == '0);
            end else begin
               state_d = S_WAIT;
               stim_d  = stim_q + STIM_ONE;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign stim       = stim_q;
   assign busy       = (state_q == S_WAIT) || (state_q == S_SAMPLE);
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign fail_cnt   = fail_cnt_q;
   assign first_fail = first_fail_q;
   assign obs_tt     = obs_tt_q;

endmodule
